// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram sample link: word width and the
// receiver state encoding used by both ends of the serial path.
package spectro_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sipo_out_reg.sv
// Single-entry ready/valid holding register for completed words; a word that
// completes while an unconsumed one is still held is dropped and flagged.
module sipo_out_reg
    import spectro_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word_in,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             can_accept;
    logic             drop_hit;

    // A held word consumed in the same cycle frees the slot for the new one.
    assign can_accept = !valid_q || out_ready;

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        drop_hit = 1'b0;
        if (word_done && can_accept) begin
            data_d  = word_in;
            valid_d = 1'b1;
        end else if (word_done) begin
            drop_hit = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        overrun_d = drop_hit | (overrun_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel receiver: frame_start marks bit 0, WIDTH bits
// make a word, completed words go to a ready/valid holding register.
module sipo_deserializer
    import spectro_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             sync_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] shifted;
    logic             busy_q, busy_d;
    logic             sync_err_q, sync_err_d;
    logic             sync_hit;
    logic             word_done;

    // New bits enter at the top and walk down, so the first bit lands in bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign shifted[gi] = serial_in;
            end else begin : g_body
                assign shifted[gi] = sr_q[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        sync_hit  = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    sr_d    = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    // Restart on the current bit; this includes a strobe that
                    // collides with the completing bit.
                    sync_hit = 1'b1;
                    sr_d     = shifted;
                    cnt_d    = CNT_W'(1);
                end else if (cnt_q == LAST_BIT) begin
                    word_done = 1'b1;
                    sr_d      = shifted;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d     = (state_d == SHIFT);
        sync_err_d = sync_hit | (sync_err_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            busy_q     <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            busy_q     <= busy_d;
            sync_err_q <= sync_err_d;
        end
    end

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .word_done(word_done),
        .word_in  (shifted),
        .out_ready(out_ready),
        .clr_err  (clr_err),
        .out_data (out_data),
        .out_valid(out_valid),
        .overrun  (overrun)
    );

    assign busy     = busy_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: inputs change 1ns after each rising
// edge and outputs are sampled at that same point.
module tb_sipo_deserializer;

    logic        clk;
    logic        rst;
    logic        serial_in;
    logic        frame_start;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        sync_err;
    logic        overrun;
    logic        clr_err;

    int checks;
    int errors;

    sipo_deserializer #(.WIDTH(12), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .frame_start(frame_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .sync_err   (sync_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b1; frame_start = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
        tick(); tick();
        rst = 1'b0; frame_start = 1'b0; serial_in = 1'b0;
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL reset.out_data: got %h expected 000", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy: got %b expected 0", busy); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset.sync_err: got %b expected 0", sync_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset.overrun: got %b expected 0", overrun); end
        $display("reset: out_data=%h out_valid=%b busy=%b", out_data, out_valid, busy);
    endtask

    task automatic test_single_word();
        logic [11:0] w;
        w = 12'hA5C;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            checks++; if (out_valid !== (c == 12)) begin errors++; $display("FAIL single.valid c=%0d: got %b expected %b", c, out_valid, (c == 12)); end
            checks++; if (busy !== (c >= 1 && c <= 11)) begin errors++; $display("FAIL single.busy c=%0d: got %b expected %b", c, busy, (c >= 1 && c <= 11)); end
            if (c == 12) begin
                checks++; if (out_data !== w) begin errors++; $display("FAIL single.data: got %h expected %h", out_data, w); end
            end
            frame_start = (c == 0);
            serial_in   = (c < 12) ? w[c] : 1'b0;
            tick();
        end
        frame_start = 1'b0;
        checks++; if ({sync_err, overrun} !== 2'b00) begin errors++; $display("FAIL single.flags: got %b expected 00", {sync_err, overrun}); end
        $display("single: word %h received, data=%h", w, out_data);
    endtask

    task automatic test_back_to_back();
        logic [11:0] w0, w1;
        w0 = 12'h001; w1 = 12'hFFE;
        out_ready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            checks++; if (out_valid !== (c == 12 || c == 24)) begin errors++; $display("FAIL b2b.valid c=%0d: got %b expected %b", c, out_valid, (c == 12 || c == 24)); end
            checks++; if (busy !== ((c >= 1 && c <= 11) || (c >= 13 && c <= 23))) begin errors++; $display("FAIL b2b.busy c=%0d: got %b", c, busy); end
            if (c == 12) begin
                checks++; if (out_data !== w0) begin errors++; $display("FAIL b2b.data0: got %h expected %h", out_data, w0); end
            end
            if (c == 24) begin
                checks++; if (out_data !== w1) begin errors++; $display("FAIL b2b.data1: got %h expected %h", out_data, w1); end
            end
            frame_start = (c == 0 || c == 12);
            if (c < 12) serial_in = w0[c];
            else if (c < 24) serial_in = w1[c-12];
            else serial_in = 1'b0;
            tick();
        end
        frame_start = 1'b0;
        checks++; if ({sync_err, overrun} !== 2'b00) begin errors++; $display("FAIL b2b.flags: got %b expected 00", {sync_err, overrun}); end
        $display("back_to_back: words %h and %h received", w0, w1);
    endtask

    task automatic test_overrun();
        logic [11:0] w0, w1;
        w0 = 12'h123; w1 = 12'h456;
        out_ready = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c >= 12) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr.valid c=%0d: got %b expected 1", c, out_valid); end
                checks++; if (out_data !== w0) begin errors++; $display("FAIL ovr.hold c=%0d: got %h expected %h", c, out_data, w0); end
            end
            frame_start = (c == 0 || c == 12);
            serial_in   = (c < 12) ? w0[c] : w1[c-12];
            tick();
        end
        frame_start = 1'b0; serial_in = 1'b0;
        checks++; if (out_data !== w0) begin errors++; $display("FAIL ovr.data_kept: got %h expected %h", out_data, w0); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr.flag: got %b expected 1", overrun); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr.consumed: got %b expected 0", out_valid); end
        checks++; if (out_data !== w0) begin errors++; $display("FAIL ovr.data_after: got %h expected %h", out_data, w0); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr.sticky: got %b expected 1", overrun); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr.cleared: got %b expected 0", overrun); end
        $display("overrun: held %h, second word %h dropped, flag cleared", w0, w1);
    endtask

    task automatic test_sync_err();
        logic [11:0] w;
        w = 12'h3C3;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++; if (out_valid !== (c == 17)) begin errors++; $display("FAIL sync.valid c=%0d: got %b expected %b", c, out_valid, (c == 17)); end
            checks++; if (sync_err !== (c >= 6)) begin errors++; $display("FAIL sync.flag c=%0d: got %b expected %b", c, sync_err, (c >= 6)); end
            if (c == 17) begin
                checks++; if (out_data !== w) begin errors++; $display("FAIL sync.data: got %h expected %h", out_data, w); end
            end
            frame_start = (c == 0 || c == 5);
            if (c < 5) serial_in = 1'b1;
            else if (c < 17) serial_in = w[c-5];
            else serial_in = 1'b0;
            tick();
        end
        frame_start = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync.cleared: got %b expected 0", sync_err); end
        $display("sync_err: restarted word %h received", w);
    endtask

    task automatic test_reset_mid_word();
        logic [11:0] w;
        w = 12'h7E1;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL rstmid.pre_sync: got %b expected 1", sync_err); end
            end
            frame_start = (c == 0 || c == 3);
            serial_in   = 1'b1;
            rst         = (c == 6);
            tick();
        end
        rst = 1'b0; frame_start = 1'b0;
        checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL rstmid.out_data: got %h expected 000", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid.out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid.busy: got %b expected 0", busy); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rstmid.sync_err: got %b expected 0", sync_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid.overrun: got %b expected 0", overrun); end
        for (int c = 0; c < 30; c++) begin
            serial_in = (c % 3 == 0);
            tick();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid.ignore c=%0d: got valid=%b busy=%b expected 0 0", c, out_valid, busy); end
        end
        for (int c = 0; c < 13; c++) begin
            checks++; if (out_valid !== (c == 12)) begin errors++; $display("FAIL rstmid.valid c=%0d: got %b expected %b", c, out_valid, (c == 12)); end
            if (c == 12) begin
                checks++; if (out_data !== w) begin errors++; $display("FAIL rstmid.data: got %h expected %h", out_data, w); end
            end
            frame_start = (c == 0);
            serial_in   = (c < 12) ? w[c] : 1'b0;
            tick();
        end
        frame_start = 1'b0;
        $display("reset_mid_word: partial discarded, word %h received", w);
    endtask

    task automatic test_same_cycle();
        logic [11:0] w0, w1;
        w0 = 12'hAAA; w1 = 12'h555;
        out_ready = 1'b0;
        for (int c = 0; c < 26; c++) begin
            if (c >= 12 && c <= 23) begin
                checks++; if (out_valid !== 1'b1 || out_data !== w0) begin errors++; $display("FAIL same.hold c=%0d: got %b/%h expected 1/%h", c, out_valid, out_data, w0); end
            end
            if (c == 24) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL same.valid: got %b expected 1", out_valid); end
                checks++; if (out_data !== w1) begin errors++; $display("FAIL same.data: got %h expected %h", out_data, w1); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same.overrun: got %b expected 0", overrun); end
            end
            if (c == 25) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL same.drained: got %b expected 0", out_valid); end
            end
            frame_start = (c == 0 || c == 12);
            if (c < 12) serial_in = w0[c];
            else if (c < 24) serial_in = w1[c-12];
            else serial_in = 1'b0;
            out_ready = (c == 23 || c == 24);
            tick();
        end
        frame_start = 1'b0; out_ready = 1'b0;
        $display("same_cycle: %h consumed while %h completed", w0, w1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; serial_in = 1'b0; frame_start = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_sync_err();
        test_reset_mid_word();
        test_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
